// File: rtl/logic_cluster.sv
// Cluster of N K-input basic logic elements with a serially loaded
// configuration chain and a small load sequencer gating the outputs.
module logic_cluster #(
    parameter int K = 4,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_en,
    input  logic           cfg_in,
    output logic           cfg_out,
    output logic           cfg_done,
    output logic           cfg_valid,
    input  logic           ce,
    input  logic [N*K-1:0] in,
    output logic [N-1:0]   out
);

    // state | meaning
    // UNCFG | after reset, no configuration seen yet, outputs forced low
    // LOAD  | shifting a configuration word, cnt = shifts taken so far
    // RUN   | configuration complete, BLEs evaluate and outputs are live

    localparam int T     = 2 ** K;
    localparam int B     = T + 3;
    localparam int CFG_W = N * B;
    localparam int CW    = $clog2(CFG_W + 1);

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [CFG_W-1:0]   cfg_q;
    logic [CFG_W-1:0]   cfg_next;
    logic [N-1:0]       q;
    logic [N-1:0]       lut;
    logic [N-1:0]       out_c;
    logic [K-1:0]       lut_idx [N];
    logic [T-1:0]       lut_tbl [N];

    assign cfg_next = {cfg_in, cfg_q[CFG_W-1:1]};
    assign cfg_out  = cfg_q[0];
    assign out      = out_c;

    // With feedback enabled the flop output replaces LUT input 0.
    always_comb begin
        lut   = '0;
        out_c = '0;
        for (int i = 0; i < N; i++) begin
            lut_tbl[i] = cfg_q[i*B +: T];
            lut_idx[i] = in[i*K +: K];
            if (cfg_q[i*B+T+2]) begin
                lut_idx[i][0] = q[i];
            end
            lut[i]   = lut_tbl[i][lut_idx[i]];
            out_c[i] = cfg_valid & (cfg_q[i*B+T] ? q[i] : lut[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= UNCFG;
            cnt       <= '0;
            cfg_q     <= '0;
            q         <= '0;
            cfg_done  <= 1'b0;
            cfg_valid <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            if (cfg_en) begin
                cfg_q <= cfg_next;
            end
            case (state)
                UNCFG: begin
                    if (cfg_en) begin
                        state <= LOAD;
                        cnt   <= CW'(1);
                    end
                end
                LOAD: begin
                    if (cfg_en) begin
                        if (cnt == CW'(CFG_W - 1)) begin
                            // Flops start from the init bits of the word just completed.
                            state     <= RUN;
                            cnt       <= '0;
                            cfg_done  <= 1'b1;
                            cfg_valid <= 1'b1;
                            for (int i = 0; i < N; i++) begin
                                q[i] <= cfg_next[i*B+T+1];
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                RUN: begin
                    if (cfg_en) begin
                        state     <= LOAD;
                        cnt       <= CW'(1);
                        cfg_valid <= 1'b0;
                    end else if (ce) begin
                        q <= lut;
                    end
                end
                default: begin
                    state     <= UNCFG;
                    cnt       <= '0;
                    cfg_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_cluster.sv
// Self-checking bench for logic_cluster: random stimulus against a
// queue-based behavioural model of the config chain and BLEs.
module tb_logic_cluster;

    localparam int K     = 4;
    localparam int N     = 4;
    localparam int T     = 16;
    localparam int B     = 19;
    localparam int CFG_W = 76;
    localparam int IW    = N * K;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_en;
    logic           cfg_in;
    logic           ce;
    logic [IW-1:0]  in_v;
    logic           cfg_out;
    logic           cfg_done;
    logic           cfg_valid;
    logic [N-1:0]   out_v;

    int total = 0;
    int bad   = 0;

    logic_cluster #(.K(K), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_en    (cfg_en),
        .cfg_in    (cfg_in),
        .cfg_out   (cfg_out),
        .cfg_done  (cfg_done),
        .cfg_valid (cfg_valid),
        .ce        (ce),
        .in        (in_v),
        .out       (out_v)
    );

    always #5 clk = ~clk;

    // Model: chain[0] is the bit presented on cfg_out; hist holds every bit
    // shifted in since the last reset.
    bit chain[$];
    bit hist[$];
    int m_mode;     // 0 unconfigured, 1 loading, 2 running
    int m_cnt;
    bit m_q[N];
    bit m_done;

    function automatic bit ble_lut(int i, logic [IW-1:0] iv);
        int idx;
        idx = int'(iv[i*K +: K]);
        if (chain[i*B+T+2]) idx = (idx & ~1) | int'(m_q[i]);
        return chain[i*B+idx];
    endfunction

    function automatic logic [N-1:0] exp_out(logic [IW-1:0] iv);
        logic [N-1:0] r;
        r = '0;
        if (m_mode == 2) begin
            for (int i = 0; i < N; i++)
                r[i] = chain[i*B+T] ? m_q[i] : ble_lut(i, iv);
        end
        return r;
    endfunction

    function automatic bit exp_cfg_out();
        if (hist.size() >= CFG_W) return hist[hist.size()-CFG_W];
        return 1'b0;
    endfunction

    function automatic logic [CFG_W-1:0] mk(int i, logic [T-1:0] tbl, bit sync, bit init,
                                           bit fb, logic [CFG_W-1:0] base);
        logic [CFG_W-1:0] w;
        w = base;
        w[i*B +: T] = tbl;
        w[i*B+T]    = sync;
        w[i*B+T+1]  = init;
        w[i*B+T+2]  = fb;
        return w;
    endfunction

    task automatic model_update();
        bit lut_old[N];
        for (int i = 0; i < N; i++) lut_old[i] = ble_lut(i, in_v);
        if (rst) begin
            for (int j = 0; j < CFG_W; j++) chain[j] = 1'b0;
            hist.delete();
            m_mode = 0;
            m_cnt  = 0;
            m_done = 1'b0;
            for (int i = 0; i < N; i++) m_q[i] = 1'b0;
        end else begin
            m_done = 1'b0;
            if (cfg_en) begin
                void'(chain.pop_front());
                chain.push_back(cfg_in);
                hist.push_back(cfg_in);
            end
            if (m_mode == 0) begin
                if (cfg_en) begin m_mode = 1; m_cnt = 1; end
            end else if (m_mode == 1) begin
                if (cfg_en) begin
                    m_cnt++;
                    if (m_cnt == CFG_W) begin
                        m_mode = 2;
                        m_cnt  = 0;
                        m_done = 1'b1;
                        for (int i = 0; i < N; i++) m_q[i] = chain[i*B+T+1];
                    end
                end
            end else begin
                if (cfg_en) begin
                    m_mode = 1;
                    m_cnt  = 1;
                end else if (ce) begin
                    for (int i = 0; i < N; i++) m_q[i] = lut_old[i];
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic load_bits(logic [CFG_W-1:0] w, int from, int to, int max_gap, int long_at);
        int gaps;
        for (int j = from; j < to; j++) begin
            gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            if (j == long_at) gaps = 22;
            for (int g = 0; g < gaps; g++) begin
                cfg_en = 1'b0;
                cfg_in = 1'($urandom());
                ce     = 1'($urandom());
                in_v   = IW'($urandom());
                #1;
                total++;
                if (out_v !== exp_out(in_v) || cfg_valid !== (m_mode == 2) || cfg_done !== m_done) begin
                    bad++;
                    $display("FAIL load_idle out=%h/%h valid=%b done=%b req out=%h done=%b",
                             out_v, exp_out(in_v), cfg_valid, cfg_done, exp_out(in_v), m_done);
                end
                tick();
            end
            cfg_en = 1'b1;
            cfg_in = w[j];
            ce     = 1'($urandom());
            in_v   = IW'($urandom());
            #1;
            total++;
            if (cfg_out !== exp_cfg_out()) begin
                bad++;
                $display("FAIL cfg_out shift=%0d got=%b req=%b", hist.size(), cfg_out, exp_cfg_out());
            end
            total++;
            if (out_v !== exp_out(in_v) || cfg_valid !== (m_mode == 2) || cfg_done !== m_done) begin
                bad++;
                $display("FAIL load_shift out=%h req=%h valid=%b done=%b req_done=%b",
                         out_v, exp_out(in_v), cfg_valid, cfg_done, m_done);
            end
            tick();
        end
        cfg_en = 1'b0;
    endtask

    task automatic run_random(int n);
        for (int c = 0; c < n; c++) begin
            cfg_en = 1'b0;
            ce     = 1'($urandom());
            in_v   = IW'($urandom());
            #1;
            total++;
            if (out_v !== exp_out(in_v)) begin
                bad++;
                $display("FAIL run_out got=%h req=%h in=%h", out_v, exp_out(in_v), in_v);
            end
            total++;
            if (cfg_valid !== (m_mode == 2) || cfg_done !== m_done) begin
                bad++;
                $display("FAIL run_flags valid=%b done=%b req valid=%b done=%b",
                         cfg_valid, cfg_done, (m_mode == 2), m_done);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_en = 1'b0; cfg_in = 1'b0; ce = 1'b0; in_v = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            ce   = 1'($urandom());
            in_v = IW'($urandom());
            cfg_in = 1'($urandom());
            #1;
            total++;
            if (out_v !== '0 || cfg_valid !== 1'b0 || cfg_done !== 1'b0 || cfg_out !== 1'b0) begin
                bad++;
                $display("FAIL reset_state out=%h valid=%b done=%b cfg_out=%b req all 0",
                         out_v, cfg_valid, cfg_done, cfg_out);
            end
            tick();
        end
    endtask

    task automatic test_comb_and();
        logic [CFG_W-1:0] w;
        w = mk(0, 16'h8000, 1'b0, 1'b0, 1'b0, '0);
        load_bits(w, 0, CFG_W, 0, -1);
        #1;
        total++;
        if (cfg_done !== 1'b1 || cfg_valid !== 1'b1) begin
            bad++;
            $display("FAIL and_done got done=%b valid=%b req 1 1", cfg_done, cfg_valid);
        end
        in_v = {(IW-4)'($urandom()), 4'hF};
        #1;
        total++;
        if (out_v !== 4'b0001) begin
            bad++;
            $display("FAIL and_all_ones got=%b req=0001", out_v);
        end
        tick();
        in_v = {(IW-4)'($urandom()), 4'hE};
        #1;
        total++;
        if (out_v !== 4'b0000 || cfg_done !== 1'b0) begin
            bad++;
            $display("FAIL and_e got=%b done=%b req 0000 0", out_v, cfg_done);
        end
        tick();
        run_random(20);
    endtask

    task automatic check_toggle(string name, bit first);
        bit v;
        v = first;
        for (int c = 0; c < 4; c++) begin
            ce   = 1'b1;
            in_v = IW'($urandom());
            #1;
            total++;
            if (out_v[1] !== v || out_v[0] !== 1'b0 || out_v[3:2] !== 2'b00) begin
                bad++;
                $display("FAIL %s_seq%0d got=%b req bit1=%b others 0", name, c, out_v, v);
            end
            v = ~v;
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            ce   = 1'b0;
            in_v = IW'($urandom());
            #1;
            total++;
            if (out_v[1] !== first) begin
                bad++;
                $display("FAIL %s_hold%0d got=%b req=%b", name, c, out_v[1], first);
            end
            tick();
        end
    endtask

    task automatic test_toggle();
        logic [CFG_W-1:0] w;
        w = mk(1, 16'h5555, 1'b1, 1'b0, 1'b1, '0);
        load_bits(w, 0, CFG_W, 0, -1);
        check_toggle("toggle", 1'b0);
        w = mk(1, 16'h5555, 1'b1, 1'b1, 1'b1, '0);
        load_bits(w, 0, CFG_W, 0, -1);
        check_toggle("toggle_init1", 1'b1);
    endtask

    task automatic test_stalled_load();
        logic [CFG_W-1:0] w;
        w = mk(1, 16'h5555, 1'b1, 1'b0, 1'b1, '0);
        load_bits(w, 0, CFG_W, 3, 30);
        check_toggle("stalled", 1'b0);
        run_random(10);
    endtask

    task automatic test_reconfig();
        logic [CFG_W-1:0] w;
        w = mk(2, 16'h6996, 1'b0, 1'b0, 1'b0, '0);
        w = mk(3, 16'hFFFE, 1'b1, 1'b1, 1'b0, w);
        load_bits(w, 0, 1, 0, -1);
        for (int c = 0; c < 3; c++) begin
            in_v = IW'($urandom());
            ce   = 1'b1;
            #1;
            total++;
            if (cfg_valid !== 1'b0 || out_v !== '0) begin
                bad++;
                $display("FAIL reconfig_drop%0d valid=%b out=%b req 0 0000", c, cfg_valid, out_v);
            end
            tick();
        end
        load_bits(w, 1, CFG_W, 0, -1);
        in_v = {4'h0, 4'b0111, 8'h00};
        #1;
        total++;
        if (cfg_valid !== 1'b1 || out_v !== 4'b1100) begin
            bad++;
            $display("FAIL reconfig_new valid=%b out=%b req 1 1100", cfg_valid, out_v);
        end
        tick();
        run_random(30);
    endtask

    task automatic test_reset_mid_load();
        logic [CFG_W-1:0] wa;
        logic [CFG_W-1:0] wb;
        wa = CFG_W'({$urandom(), $urandom(), $urandom()});
        load_bits(wa, 0, 40, 0, -1);
        rst    = 1'b1;
        cfg_en = 1'b1;
        cfg_in = 1'b1;
        tick();
        rst    = 1'b0;
        cfg_en = 1'b0;
        #1;
        total++;
        if (cfg_valid !== 1'b0 || out_v !== '0 || cfg_out !== 1'b0 || cfg_done !== 1'b0) begin
            bad++;
            $display("FAIL midreset valid=%b out=%b cfg_out=%b done=%b req all 0",
                     cfg_valid, out_v, cfg_out, cfg_done);
        end
        wb = mk(0, 16'h8000, 1'b0, 1'b0, 1'b0, '0);
        load_bits(wb, 0, CFG_W, 0, -1);
        in_v = {12'h000, 4'hF};
        #1;
        total++;
        if (cfg_done !== 1'b1 || out_v !== 4'b0001) begin
            bad++;
            $display("FAIL midreset_reload done=%b out=%b req 1 0001", cfg_done, out_v);
        end
        tick();
        run_random(20);
    endtask

    initial begin
        for (int j = 0; j < CFG_W; j++) chain.push_back(1'b0);
        m_mode = 0; m_cnt = 0; m_done = 1'b0;
        for (int i = 0; i < N; i++) m_q[i] = 1'b0;
        rst = 1'b1; cfg_en = 1'b0; cfg_in = 1'b0; ce = 1'b0; in_v = '0;
        @(negedge clk);
        test_reset();
        test_comb_and();
        test_toggle();
        test_stalled_load();
        test_reconfig();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
